// File: rtl/fft_pkg.sv
// Shared constants, state encodings and index helpers for the FFT output reorder block.
package fft_pkg;

    localparam int unsigned MAX_LDN_DEF = 11;
    localparam int unsigned LDN_W       = 4;
    localparam int unsigned BR_W        = 16;
    localparam logic [LDN_W-1:0] LDN_MIN = 4'd1;

    typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_RUN  = 1'b1} rd_state_t;

    // Bound a requested block size to the supported range.
    function automatic logic [LDN_W-1:0] clip_ldn(input logic [LDN_W-1:0] ldn,
                                                  input logic [LDN_W-1:0] max_ldn);
        logic [LDN_W-1:0] r;
        r = ldn;
        if (ldn > max_ldn) r = max_ldn;
        if (ldn < LDN_MIN) r = LDN_MIN;
        return r;
    endfunction

    // Index of the last sample in a 2^ldn block.
    function automatic logic [BR_W-1:0] ldn_mask(input logic [LDN_W-1:0] ldn);
        return (BR_W'(1) << ldn) - BR_W'(1);
    endfunction

    // Reverse the low ldn bits of value; bits above ldn come back zero.
    function automatic logic [BR_W-1:0] bitrev(input logic [BR_W-1:0] value,
                                               input logic [LDN_W-1:0] ldn);
        logic [BR_W-1:0] r;
        r = '0;
        for (int i = 0; i < BR_W; i++) begin
            for (int j = 0; j < BR_W; j++) begin
                if (i + j + 1 == int'(ldn)) r[j] = value[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Sample stream in/out of the reorder block.
// master: FFT-side source / downstream sink (drives *_i, observes *_o)
// slave : the reorder block (observes *_i, drives *_o)
interface fft_out_reorder_if import fft_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic                         block_sync_i;
    logic                         data_val_i;
    logic signed [DATA_WIDTH-1:0] data_real_i;
    logic signed [DATA_WIDTH-1:0] data_imag_i;
    logic [LDN_W-1:0]             ldn_rg_i;
    logic                         block_sync_o;
    logic                         data_val_o;
    logic signed [DATA_WIDTH-1:0] data_real_o;
    logic signed [DATA_WIDTH-1:0] data_imag_o;
    logic                         ovf_o;

    modport master (
        output block_sync_i, data_val_i, data_real_i, data_imag_i, ldn_rg_i,
        input  block_sync_o, data_val_o, data_real_o, data_imag_o, ovf_o
    );

    modport slave (
        input  block_sync_i, data_val_i, data_real_i, data_imag_i, ldn_rg_i,
        output block_sync_o, data_val_o, data_real_o, data_imag_o, ovf_o
    );
endinterface

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// clk   : clock
// we/waddr/wdata : write port
// re/raddr/rdata : read port, rdata valid the cycle after re
module fft_reorder_ram #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_out_reorder.sv
// Reorders bit-reversed FFT output blocks into natural frequency order.
// Ping-pong buffered: one bank fills while the other streams out.
// clk_sys   : system clock
// rst_sys_n : asynchronous active-low reset
// bus       : slave side of the sample stream (input framing/data, ldn, output framing/data, ovf pulse)
module fft_out_reorder import fft_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_LDN    = MAX_LDN_DEF
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    fft_out_reorder_if.slave bus
);
    localparam int unsigned CNT_W  = MAX_LDN;
    localparam int unsigned ADDR_W = MAX_LDN + 1;
    localparam int unsigned WORD_W = 2 * DATA_WIDTH;
    localparam logic [LDN_W-1:0] LDN_MAX = LDN_W'(MAX_LDN);

    wr_state_t        w_state, w_state_n;
    logic [LDN_W-1:0] w_ldn, w_ldn_n;
    logic [CNT_W-1:0] wcnt, wcnt_n;
    logic             w_bank, w_bank_n;

    rd_state_t        r_state, r_state_n;
    logic [LDN_W-1:0] r_ldn, r_ldn_n;
    logic [CNT_W-1:0] rcnt, rcnt_n;
    logic             r_bank, r_bank_n;

    logic              start_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic              handoff_c;
    logic              ovf_c;
    logic              read_free_c;
    logic [CNT_W-1:0]  r_mask_c;
    logic              rd_en_c;
    logic              rd_first_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [WORD_W-1:0] rd_data;

    logic                  rd_val_q;
    logic                  rd_sync_q;
    logic                  block_sync_q;
    logic                  data_val_q;
    logic                  ovf_q;
    logic [DATA_WIDTH-1:0] real_q;
    logic [DATA_WIDTH-1:0] imag_q;

    assign start_c  = bus.data_val_i && bus.block_sync_i;
    assign r_mask_c = CNT_W'(ldn_mask(r_ldn));
    // Read side can accept a bank now if idle or issuing its final address this cycle.
    assign read_free_c = (r_state == R_IDLE) || (rcnt == r_mask_c);

    // Write FSM: scatter samples to bit-reversed addresses, hand off on block completion.
    always_comb begin
        w_state_n = w_state;
        w_ldn_n   = w_ldn;
        wcnt_n    = wcnt;
        w_bank_n  = w_bank;
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        handoff_c = 1'b0;
        ovf_c     = 1'b0;
        if (start_c) begin
            // A sync mid-block discards the partial block and refills the same bank.
            w_ldn_n   = clip_ldn(bus.ldn_rg_i, LDN_MAX);
            wcnt_n    = CNT_W'(1);
            wr_en_c   = 1'b1;
            wr_addr_c = {w_bank, CNT_W'(0)};
            w_state_n = W_FILL;
        end else if (w_state == W_FILL && bus.data_val_i) begin
            wr_en_c   = 1'b1;
            wr_addr_c = {w_bank, CNT_W'(bitrev(BR_W'(wcnt), w_ldn))};
            wcnt_n    = wcnt + CNT_W'(1);
            if (BR_W'(wcnt) == ldn_mask(w_ldn)) begin
                wcnt_n    = '0;
                w_state_n = W_IDLE;
                if (read_free_c) begin
                    handoff_c = 1'b1;
                    w_bank_n  = ~w_bank;
                end else begin
                    ovf_c = 1'b1;
                end
            end
        end
    end

    // Read FSM: sweep natural addresses one per cycle; reload without a bubble on handoff.
    always_comb begin
        r_state_n  = r_state;
        r_ldn_n    = r_ldn;
        rcnt_n     = rcnt;
        r_bank_n   = r_bank;
        rd_en_c    = 1'b0;
        rd_first_c = 1'b0;
        if (r_state == R_RUN) begin
            rd_en_c    = 1'b1;
            rd_first_c = (rcnt == '0);
            rcnt_n     = rcnt + CNT_W'(1);
            if (rcnt == r_mask_c) begin
                r_state_n = R_IDLE;
            end
        end
        if (handoff_c) begin
            r_state_n = R_RUN;
            rcnt_n    = '0;
            r_ldn_n   = w_ldn;
            r_bank_n  = w_bank;
        end
    end

    assign rd_addr_c = {r_bank, rcnt};

    // State, counters and output pipeline.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            w_state      <= W_IDLE;
            w_ldn        <= LDN_MIN;
            wcnt         <= '0;
            w_bank       <= 1'b0;
            r_state      <= R_IDLE;
            r_ldn        <= LDN_MIN;
            rcnt         <= '0;
            r_bank       <= 1'b0;
            rd_val_q     <= 1'b0;
            rd_sync_q    <= 1'b0;
            block_sync_q <= 1'b0;
            data_val_q   <= 1'b0;
            ovf_q        <= 1'b0;
            real_q       <= '0;
            imag_q       <= '0;
        end else begin
            w_state      <= w_state_n;
            w_ldn        <= w_ldn_n;
            wcnt         <= wcnt_n;
            w_bank       <= w_bank_n;
            r_state      <= r_state_n;
            r_ldn        <= r_ldn_n;
            rcnt         <= rcnt_n;
            r_bank       <= r_bank_n;
            rd_val_q     <= rd_en_c;
            rd_sync_q    <= rd_first_c;
            block_sync_q <= rd_sync_q;
            data_val_q   <= rd_val_q;
            ovf_q        <= ovf_c;
            if (rd_val_q) begin
                real_q <= rd_data[WORD_W-1:DATA_WIDTH];
                imag_q <= rd_data[DATA_WIDTH-1:0];
            end
        end
    end

    fft_reorder_ram #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk_sys),
        .we    (wr_en_c),
        .waddr (wr_addr_c),
        .wdata ({bus.data_real_i, bus.data_imag_i}),
        .re    (rd_en_c),
        .raddr (rd_addr_c),
        .rdata (rd_data)
    );

    assign bus.block_sync_o = block_sync_q;
    assign bus.data_val_o   = data_val_q;
    assign bus.data_real_o  = real_q;
    assign bus.data_imag_o  = imag_q;
    assign bus.ovf_o        = ovf_q;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: framing, latency, ordering, overflow, restart and reset.
module tb_fft_out_reorder;
    localparam int DW = 16;

    logic clk_sys = 1'b0;
    logic rst_sys_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ovf_cnt  = 0;
    int   stray_sync = 0;

    logic [15:0] q_re[$];
    logic [15:0] q_im[$];
    bit          q_sync[$];
    int          q_cyc[$];

    always #5 clk_sys = ~clk_sys;

    fft_out_reorder_if #(.DATA_WIDTH(DW)) bus ();

    fft_out_reorder #(.DATA_WIDTH(DW), .MAX_LDN(11)) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus       (bus)
    );

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_sys) begin
        if (bus.data_val_o === 1'b1) begin
            q_re.push_back(bus.data_real_o);
            q_im.push_back(bus.data_imag_o);
            q_sync.push_back(bus.block_sync_o);
            q_cyc.push_back(cyc);
        end else if (bus.block_sync_o === 1'b1) begin
            stray_sync++;
        end
        if (bus.ovf_o === 1'b1) ovf_cnt++;
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ref_bitrev(input int v, input int ldn);
        int r = 0;
        for (int i = 0; i < ldn; i++) begin
            r = (r << 1) | (v & 1);
            v = v >> 1;
        end
        return r;
    endfunction

    task automatic drive(input bit sync, input bit val, input logic [3:0] ldn,
                         input logic [15:0] re, input logic [15:0] im);
        @(negedge clk_sys);
        bus.block_sync_i = sync;
        bus.data_val_i   = val;
        bus.ldn_rg_i     = ldn;
        bus.data_real_i  = re;
        bus.data_imag_i  = im;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 4'd0, 16'h0, 16'h0);
    endtask

    task automatic clear_q();
        q_re.delete();
        q_im.delete();
        q_sync.delete();
        q_cyc.delete();
        ovf_cnt = 0;
    endtask

    // Sample k carries re=base+k, im=-(base+k); acc_cyc is the cycle index of the accepting edge.
    task automatic send_block(input logic [3:0] ldn, input int n, input int base,
                              input int gap_pct, output int acc_cyc);
        for (int k = 0; k < n; k++) begin
            while (k > 0 && int'($urandom_range(99, 0)) < gap_pct) drive_idle();
            drive(k == 0, 1'b1, ldn, 16'(base + k), 16'(-(base + k)));
        end
        acc_cyc = cyc + 1;
    endtask

    task automatic collect(input int n, input int budget, input string name);
        int waited = 0;
        while (q_re.size() < n && waited < budget) begin
            @(negedge clk_sys);
            waited++;
        end
        repeat (8) @(negedge clk_sys);
        checks++;
        if (q_re.size() != n) begin
            failures++;
            $display("FAIL %s_count: got %0d outputs, expected %0d", name, q_re.size(), n);
        end
    endtask

    // Bin j must hold input sample bitrev(j), sync only on bin 0, and no gaps.
    task automatic check_block(input int idx0, input int ldn, input int base, input string name);
        int n = 1 << ldn;
        int errs = 0;
        int first_bad = -1;
        int src;
        for (int j = 0; j < n; j++) begin
            if (idx0 + j >= q_re.size()) begin
                errs++;
                if (first_bad < 0) first_bad = j;
            end else begin
                src = base + ref_bitrev(j, ldn);
                if (q_re[idx0 + j] !== 16'(src) || q_im[idx0 + j] !== 16'(-src) ||
                    q_sync[idx0 + j] != (j == 0) || q_cyc[idx0 + j] != q_cyc[idx0] + j) begin
                    errs++;
                    if (first_bad < 0) first_bad = j;
                end
            end
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL %s_data: %0d bad bins (first bin %0d), expected 0", name, errs, first_bad);
        end
    endtask

    task automatic check_ovf(input int expected, input string name);
        checks++;
        if (ovf_cnt != expected) begin
            failures++;
            $display("FAIL %s_ovf: got %0d pulses, expected %0d", name, ovf_cnt, expected);
        end
    endtask

    task automatic test_reset();
        rst_sys_n = 1'b0;
        bus.block_sync_i = 1'b0;
        bus.data_val_i   = 1'b0;
        bus.ldn_rg_i     = 4'd0;
        bus.data_real_i  = '0;
        bus.data_imag_i  = '0;
        repeat (3) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        checks += 5;
        if (bus.data_val_o !== 1'b0) begin failures++; $display("FAIL reset_val: got %b expected 0", bus.data_val_o); end
        if (bus.block_sync_o !== 1'b0) begin failures++; $display("FAIL reset_sync: got %b expected 0", bus.block_sync_o); end
        if (bus.data_real_o !== 16'h0) begin failures++; $display("FAIL reset_real: got %h expected 0", bus.data_real_o); end
        if (bus.data_imag_o !== 16'h0) begin failures++; $display("FAIL reset_imag: got %h expected 0", bus.data_imag_o); end
        if (bus.ovf_o !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf_o); end
    endtask

    // ldn=3, re=bitrev(k), im=-k: natural order gives re=j, im=-bitrev(j).
    task automatic test_basic();
        int in_re[8];
        int exp_im[8];
        int acc;
        in_re  = '{0, 4, 2, 6, 1, 5, 3, 7};
        exp_im = '{0, -4, -2, -6, -1, -5, -3, -7};
        clear_q();
        for (int k = 0; k < 8; k++) drive(k == 0, 1'b1, 4'd3, 16'(in_re[k]), 16'(-k));
        acc = cyc + 1;
        drive_idle();
        collect(8, 40, "basic");
        for (int j = 0; j < 8 && j < q_re.size(); j++) begin
            checks += 3;
            if (q_re[j] !== 16'(j)) begin failures++; $display("FAIL basic_re[%0d]: got %h expected %h", j, q_re[j], 16'(j)); end
            if (q_im[j] !== 16'(exp_im[j])) begin failures++; $display("FAIL basic_im[%0d]: got %h expected %h", j, q_im[j], 16'(exp_im[j])); end
            if (q_sync[j] != (j == 0)) begin failures++; $display("FAIL basic_sync[%0d]: got %0d expected %0d", j, q_sync[j], j == 0); end
        end
        if (q_cyc.size() == 8) begin
            checks += 2;
            if (q_cyc[0] != acc + 2) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", q_cyc[0] - acc, 2); end
            if (q_cyc[7] - q_cyc[0] != 7) begin failures++; $display("FAIL basic_contig: span %0d expected 7", q_cyc[7] - q_cyc[0]); end
        end
        check_ovf(0, "basic");
    endtask

    task automatic test_back_to_back();
        int acc;
        clear_q();
        stray_sync = 0;
        send_block(4'd11, 2048, 16'h0000, 0, acc);
        send_block(4'd11, 2048, 16'h4000, 0, acc);
        drive_idle();
        collect(4096, 4200, "b2b");
        check_block(0, 11, 16'h0000, "b2b_blk0");
        check_block(2048, 11, 16'h4000, "b2b_blk1");
        checks++;
        if (q_cyc.size() == 4096 && q_cyc[4095] - q_cyc[0] != 4095) begin
            failures++;
            $display("FAIL b2b_contig: span %0d expected 4095", q_cyc[4095] - q_cyc[0]);
        end else if (q_cyc.size() != 4096) begin
            failures++;
            $display("FAIL b2b_contig: %0d outputs expected 4096", q_cyc.size());
        end
        checks++;
        if (stray_sync != 0) begin failures++; $display("FAIL b2b_stray_sync: got %0d expected 0", stray_sync); end
        check_ovf(0, "b2b");
    endtask

    task automatic test_gaps();
        int acc;
        clear_q();
        send_block(4'd4, 16, 16'h0100, 50, acc);
        drive_idle();
        collect(16, 60, "gaps");
        check_block(0, 4, 16'h0100, "gaps");
        check_ovf(0, "gaps");
    endtask

    task automatic test_restart();
        int acc;
        clear_q();
        send_block(4'd5, 5, 16'h0200, 0, acc);
        send_block(4'd4, 16, 16'h0300, 0, acc);
        drive_idle();
        collect(16, 60, "restart");
        check_block(0, 4, 16'h0300, "restart");
        check_ovf(0, "restart");
    endtask

    task automatic test_overflow();
        int acc;
        clear_q();
        send_block(4'd11, 2048, 16'h1000, 0, acc);
        send_block(4'd2, 4, 16'h2000, 0, acc);
        drive_idle();
        collect(2048, 2200, "ovf");
        check_block(0, 11, 16'h1000, "ovf_big");
        check_ovf(1, "ovf");
        clear_q();
        send_block(4'd2, 4, 16'h2100, 0, acc);
        drive_idle();
        collect(4, 40, "ovf_recover");
        check_block(0, 2, 16'h2100, "ovf_recover");
        check_ovf(0, "ovf_recover");
    endtask

    task automatic test_clip();
        int acc;
        clear_q();
        send_block(4'd0, 2, 16'h0050, 0, acc);
        drive_idle();
        collect(2, 40, "clip_lo");
        check_block(0, 1, 16'h0050, "clip_lo");
        clear_q();
        send_block(4'd15, 2048, 16'h6000, 0, acc);
        drive_idle();
        collect(2048, 2200, "clip_hi");
        check_block(0, 11, 16'h6000, "clip_hi");
    endtask

    task automatic test_reset_mid();
        int acc;
        int waited = 0;
        clear_q();
        send_block(4'd6, 64, 16'h0600, 0, acc);
        drive_idle();
        while (q_re.size() < 10 && waited < 100) begin
            @(negedge clk_sys);
            waited++;
        end
        checks++;
        if (q_re.size() < 10) begin failures++; $display("FAIL rstmid_started: got %0d outputs expected >=10", q_re.size()); end
        #2 rst_sys_n = 1'b0;
        #1;
        checks += 4;
        if (bus.data_val_o !== 1'b0) begin failures++; $display("FAIL rstmid_val: got %b expected 0", bus.data_val_o); end
        if (bus.block_sync_o !== 1'b0) begin failures++; $display("FAIL rstmid_sync: got %b expected 0", bus.block_sync_o); end
        if (bus.data_real_o !== 16'h0) begin failures++; $display("FAIL rstmid_real: got %h expected 0", bus.data_real_o); end
        if (bus.data_imag_o !== 16'h0) begin failures++; $display("FAIL rstmid_imag: got %h expected 0", bus.data_imag_o); end
        repeat (2) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        clear_q();
        repeat (80) @(negedge clk_sys);
        checks++;
        if (q_re.size() != 0) begin failures++; $display("FAIL rstmid_abandon: got %0d outputs expected 0", q_re.size()); end
        send_block(4'd3, 8, 16'h0700, 0, acc);
        drive_idle();
        collect(8, 40, "rstmid_new");
        check_block(0, 3, 16'h0700, "rstmid_new");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gaps();
        test_restart();
        test_overflow();
        test_clip();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
